dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the data memory block.
- Port 0 is the core load/store unit; port 1 is the DMA/boot-loader port.
- Selects one requester per access by round-robin and registers the winner's command.
- Drives MemRead/MemWrite/a/wd/Funct3 for exactly one cycle, captures rd, and returns it with a valid pulse. Rejects misaligned accesses without touching memory.

Parameters:
DM_ADDRESS, 9, memory byte-address width.
DATA_W, 32, data width.

Ports:
clk  in  1  system clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
m0_req  in  1  port 0 access request; held with payload until m0_gnt.
m0_we  in  1  port 0: 1 = store, 0 = load.
m0_addr  in  DM_ADDRESS  port 0 byte address.
m0_wdata  in  DATA_W  port 0 store data.
m0_funct3  in  3  port 0 size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
m0_gnt  out  1  one-cycle pulse: port 0 command accepted.
m0_rvalid  out  1  one-cycle pulse: port 0 access completed (load or store).
m0_rdata  out  DATA_W  port 0 load data; valid with m0_rvalid.
m0_err  out  1  port 0 misaligned-access flag; valid with m0_rvalid.
m1_*  same set as m0_*, for port 1.
MemRead  out  1  to data memory.
MemWrite  out  1  to data memory.
a  out  DM_ADDRESS  to data memory.
wd  out  DATA_W  to data memory.
Funct3  out  3  to data memory.
rd  in  DATA_W  read data from data memory.

Behaviour:
- Reset:
  - Asynchronous on rst_n=0. State goes to IDLE and all outputs go to 0.
  - The round-robin pointer last_gnt is set to 1, so port 0 wins the first tie.
  - Reset mid-access abandons that access: no rvalid, and no memory strobe after reset.
- FSM states:
  - IDLE: wait for a request.
  - ISSUE: memory strobes active.
  - RESP: return results.
- IDLE:
  - If any req is high, pick the winner. A single requester wins outright; with both high, the port != last_gnt wins.
  - Latch winner id, we, addr, wdata, funct3 and the alignment result, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - gnt[winner]=1 and last_gnt is updated.
  - If aligned: MemRead=!we and MemWrite=we; a/wd/Funct3 come from latched registers.
  - If misaligned: both strobes stay 0.
  - rd is captured into an internal register at the end of the cycle. Next state is RESP.
- RESP (1 cycle):
  - rvalid[winner]=1 and rdata=captured rd (0 for stores or misaligned accesses); err=misaligned.
  - Requests are evaluated exactly as in IDLE; with a request go to ISSUE, otherwise go to IDLE.
- Timing and throughput:
  - Latency is req sampled at edge N, gnt and strobes in cycle N+1, rvalid in N+2.
  - Back-to-back throughput is one access per 2 cycles.
- Requester rules:
  - A requester keeps req high until it sees gnt.
  - Dropping req before gnt is legal; the request is simply not sampled.
  - A requester may reassert req in its RESP cycle for the next access.
- Memory outputs:
  - MemRead and MemWrite are never both 1.
  - Both are 0 outside ISSUE. a/wd/Funct3 hold their last value outside ISSUE.
- Misaligned accesses (no memory access, err=1):
  - funct3 001/101 (halfword) with addr[0]=1.
  - funct3 010 (word) with addr[1:0]!=0.
  - Byte accesses are never misaligned.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1; no port waits more than one foreign access.
- rdata for the non-winning port holds its previous value; only its rvalid qualifies it.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101);
  - port-id constants.
- One combinational sub-module, dmem_align_check, takes (addr[1:0], funct3) and returns misaligned. It is instantiated once on the winner's inputs before latching.

Test Plan:
- Reset then single load: m0 req LW addr 0x010 at edge 1 -> m0_gnt and MemRead=1, a=0x010 in cycle 2; m0_rvalid with rdata=memory word (preloaded 0xDEADBEEF) in cycle 3; err=0.
- Simultaneous requests: m0 SW 0x11111111@0x020 and m1 SW 0x22222222@0x024 held high -> grants in order m0,m1, 2 cycles apart; memory contains both words afterwards; MemWrite never overlaps MemRead.
- Continuous contention: both ports issue 8 back-to-back LBU requests -> grant sequence 0,1,0,1,…; each rvalid 1 cycle after its gnt; byte values match preloaded data.
- Misaligned access: m1 SH addr 0x003 -> m1_gnt, MemWrite stays 0, m1_rvalid with err=1, rdata=0; memory unchanged. Likewise LW addr 0x002 -> err=1.
- Reset mid-operation: assert rst_n=0 during ISSUE of an SB -> all outputs 0 immediately, no rvalid afterwards; after release, m1-only request is granted first and m0 wins the next tie.
- Withdrawn request: m1 raises req for a cycle while m0 is in ISSUE, then drops it before RESP -> m1 never granted, FSM returns to IDLE, no spurious strobes.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and encodings for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned F3_BITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

endpackage

// File: rtl/dmem_align_check.sv
// Flags halfword/word accesses whose byte address is not naturally aligned.
module dmem_align_check
  import dmem_arb_pkg::*;
(
  input  logic [1:0]         addr_lo_i,
  input  logic [F3_BITS-1:0] funct3_i,
  output logic               misaligned_c_o
);

  always_comb begin
    misaligned_c_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: misaligned_c_o = 1'b0;
      F3_H, F3_HU: misaligned_c_o = addr_lo_i[0];
      F3_W:        misaligned_c_o = |addr_lo_i;
      default:     misaligned_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-cycle sequencer for the data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DM_ADDRESS-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [F3_BITS-1:0]    m0_funct3,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DM_ADDRESS-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [F3_BITS-1:0]    m1_funct3,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [F3_BITS-1:0]    Funct3,
  input  logic [DATA_W-1:0]     rd
);

  state_e                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  win_q, win_d;
  logic                  we_q, we_d;
  logic                  mis_q, mis_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_W-1:0]     rdata0_q, rdata0_d;
  logic [DATA_W-1:0]     rdata1_q, rdata1_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [DM_ADDRESS-1:0] a_q, a_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic [F3_BITS-1:0]    f3_q, f3_d;

  logic                  any_req_c;
  logic                  win_c;
  logic                  win_we_c;
  logic [DM_ADDRESS-1:0] win_addr_c;
  logic [DATA_W-1:0]     win_wdata_c;
  logic [F3_BITS-1:0]    win_f3_c;
  logic                  mis_c;
  logic [DATA_W-1:0]     resp_data_c;

  // On a tie the port that did not win last time goes first.
  assign any_req_c   = m0_req | m1_req;
  assign win_c       = (m0_req & m1_req) ? ~last_gnt_q : m1_req;
  assign win_we_c    = win_c ? m1_we     : m0_we;
  assign win_addr_c  = win_c ? m1_addr   : m0_addr;
  assign win_wdata_c = win_c ? m1_wdata  : m0_wdata;
  assign win_f3_c    = win_c ? m1_funct3 : m0_funct3;
  assign resp_data_c = (we_q | mis_q) ? '0 : rd;

  dmem_align_check u_align (
    .addr_lo_i      (win_addr_c[1:0]),
    .funct3_i       (win_f3_c),
    .misaligned_c_o (mis_c)
  );

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    win_d       = win_q;
    we_d        = we_q;
    mis_d       = mis_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    err_d       = err_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    a_d         = a_q;
    wd_d        = wd_q;
    f3_d        = f3_q;
    case (state_q)
      ISSUE: begin
        state_d         = RESP;
        rvalid_d[win_q] = 1'b1;
        err_d[win_q]    = mis_q;
        if (win_q == PORT_1) rdata1_d = resp_data_c;
        else                 rdata0_d = resp_data_c;
      end
      // IDLE and RESP arbitrate identically; the spare encoding recovers here too.
      default: begin
        if (any_req_c) begin
          state_d       = ISSUE;
          last_gnt_d    = win_c;
          win_d         = win_c;
          we_d          = win_we_c;
          mis_d         = mis_c;
          gnt_d[win_c]  = 1'b1;
          mem_read_d    = ~mis_c & ~win_we_c;
          mem_write_d   = ~mis_c & win_we_c;
          a_d           = win_addr_c;
          wd_d          = win_wdata_c;
          f3_d          = win_f3_c;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_1;
      win_q       <= PORT_0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_q         <= '0;
      wd_q        <= '0;
      f3_q        <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      win_q       <= win_d;
      we_q        <= we_d;
      mis_q       <= mis_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      a_q         <= a_d;
      wd_q        <= wd_d;
      f3_q        <= f3_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign a         = a_q;
  assign wd        = wd_q;
  assign Funct3    = f3_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, corner sequences, random traffic vs reference.
module tb_dmem_arbiter;

  localparam int unsigned AW  = 9;
  localparam int unsigned DW  = 32;
  localparam int unsigned MEM = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [2:0]    m0_funct3, m1_funct3;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          MemRead, MemWrite;
  logic [AW-1:0] a;
  logic [DW-1:0] wd, rd;
  logic [2:0]    Funct3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd)
  );

  // Data memory environment: combinational read with size/sign handling, write on the clock.
  logic [7:0]  dmem [MEM];
  logic [31:0] env_w;
  always_comb begin
    env_w = '0;
    for (int i = 0; i < 4; i++) env_w[8*i +: 8] = dmem[AW'(a + AW'(i))];
    case (Funct3)
      3'b000:  rd = {{24{env_w[7]}}, env_w[7:0]};
      3'b001:  rd = {{16{env_w[15]}}, env_w[15:0]};
      3'b100:  rd = {24'h0, env_w[7:0]};
      3'b101:  rd = {16'h0, env_w[15:0]};
      default: rd = env_w;
    endcase
  end
  always @(posedge clk) begin
    if (MemWrite) begin
      dmem[a] = wd[7:0];
      if (Funct3[1:0] != 2'b00) dmem[AW'(a + 9'd1)] = wd[15:8];
      if (Funct3[1:0] == 2'b10) begin
        dmem[AW'(a + 9'd2)] = wd[23:16];
        dmem[AW'(a + 9'd3)] = wd[31:24];
      end
    end
  end

  // Reference memory, updated only by the model's idea of which accesses happened.
  logic [7:0] ref_mem [MEM];

  function automatic void ref_access(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                                     input logic [2:0] f3, output logic [31:0] rdata, output logic err);
    int nb;
    logic [31:0] v;
    nb    = 1 << f3[1:0];
    err   = (int'(addr) % nb) != 0;
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[(int'(addr) + i) % MEM] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(int'(addr) + i) % MEM]) << (8 * i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      rdata = v;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic gnt_of(input logic p);         return p ? m1_gnt    : m0_gnt;    endfunction
  function automatic logic rv_of(input logic p);          return p ? m1_rvalid : m0_rvalid; endfunction
  function automatic logic err_of(input logic p);         return p ? m1_err    : m0_err;    endfunction
  function automatic logic [31:0] rdata_of(input logic p); return p ? m1_rdata : m0_rdata;  endfunction

  task automatic drive(input logic p, input logic req, input logic we, input logic [8:0] addr,
                       input logic [31:0] wdv, input logic [2:0] f3);
    if (p) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdv; m1_funct3 = f3; end
    else   begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdv; m0_funct3 = f3; end
  endtask

  task automatic set_req(input logic p, input logic v);
    if (p) m1_req = v; else m0_req = v;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] env_word(input int addr);
    return {dmem[addr+3], dmem[addr+2], dmem[addr+1], dmem[addr]};
  endfunction

  typedef struct {
    logic        port;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // One isolated access: gnt and strobes next cycle, response the cycle after.
  task automatic run_single(input vec_t v);
    logic [31:0] dr;
    logic de;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.f3);
    tick();
    chk("vec_gnt", 32'(gnt_of(v.port)), 32'd1);
    chk("vec_other_gnt", 32'(gnt_of(~v.port)), 32'd0);
    chk("vec_memread", 32'(MemRead), 32'(!v.exp_err && !v.we));
    chk("vec_memwrite", 32'(MemWrite), 32'(!v.exp_err && v.we));
    if (!v.exp_err) chk("vec_addr", 32'(a), 32'(v.addr));
    set_req(v.port, 1'b0);
    tick();
    chk("vec_rvalid", 32'(rv_of(v.port)), 32'd1);
    chk("vec_rdata", rdata_of(v.port), v.exp_rdata);
    chk("vec_err", 32'(err_of(v.port)), 32'(v.exp_err));
    ref_access(v.we, v.addr, v.wdata, v.f3, dr, de);
  endtask

  // Transaction-level model state and per-cycle expectations.
  bit          m_cool;
  logic        m_last, m_pport, m_perr;
  logic [31:0] m_prd;
  logic [1:0]  e_gnt, e_rv;
  logic        e_mr, e_mw, e_err, e_port;
  logic [8:0]  e_a;
  logic [31:0] e_wd, e_rd;
  logic [2:0]  e_f3;

  task automatic model_step();
    logic w, we;
    logic [8:0] ad;
    logic [31:0] wdv, r;
    logic [2:0] f3;
    logic er;
    e_gnt = '0; e_rv = '0; e_mr = 1'b0; e_mw = 1'b0;
    if (m_cool) begin
      m_cool = 1'b0;
      e_rv[m_pport] = 1'b1;
      e_port = m_pport; e_rd = m_prd; e_err = m_perr;
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) w = (m_last == 1'b0) ? 1'b1 : 1'b0;
      else if (m0_req)      w = 1'b0;
      else                  w = 1'b1;
      we  = w ? m1_we : m0_we;
      ad  = w ? m1_addr : m0_addr;
      wdv = w ? m1_wdata : m0_wdata;
      f3  = w ? m1_funct3 : m0_funct3;
      ref_access(we, ad, wdv, f3, r, er);
      e_gnt[w] = 1'b1;
      e_mr = !er && !we; e_mw = !er && we;
      e_a = ad; e_wd = wdv; e_f3 = f3;
      m_pport = w; m_prd = r; m_perr = er; m_cool = 1'b1; m_last = w;
    end
  endtask

  task automatic check_cycle();
    chk("rnd_gnt0", 32'(m0_gnt), 32'(e_gnt[0]));
    chk("rnd_gnt1", 32'(m1_gnt), 32'(e_gnt[1]));
    chk("rnd_rvalid0", 32'(m0_rvalid), 32'(e_rv[0]));
    chk("rnd_rvalid1", 32'(m1_rvalid), 32'(e_rv[1]));
    chk("rnd_memread", 32'(MemRead), 32'(e_mr));
    chk("rnd_memwrite", 32'(MemWrite), 32'(e_mw));
    if (e_mr || e_mw) begin
      chk("rnd_a", 32'(a), 32'(e_a));
      chk("rnd_funct3", 32'(Funct3), 32'(e_f3));
    end
    if (e_mw) chk("rnd_wd", wd, e_wd);
    if (e_rv != 2'b00) begin
      chk("rnd_rdata", rdata_of(e_port), e_rd);
      chk("rnd_err", 32'(err_of(e_port)), 32'(e_err));
    end
  endtask

  task automatic rand_op(input logic p, input bit lbu_only);
    logic we;
    logic [2:0] f3;
    if (lbu_only) begin
      we = 1'b0; f3 = 3'b100;
    end else begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      if (we) f3[2] = 1'b0;
    end
    drive(p, 1'b1, we, 9'($urandom), $urandom, f3);
  endtask

  // Requesters obey the hold-until-gnt rule; random mode also withdraws occasionally.
  task automatic run_traffic(input int cycles, input bit contention, output int issued0,
                             output int issued1, inout int gseq[$]);
    int issued [2];
    issued = '{0, 0};
    m_cool = 1'b0; m_last = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (gnt_of(1'(p))) begin
          set_req(1'(p), 1'b0);
          issued[p]++;
          if (contention) gseq.push_back(p);
        end else if (!(p == 1 ? m1_req : m0_req)) begin
          if (contention) begin
            if (issued[p] < 8) rand_op(1'(p), 1'b1);
          end else if ($urandom_range(0, 2) == 0) begin
            rand_op(1'(p), 1'b0);
          end
        end else if (!contention && $urandom_range(0, 7) == 0) begin
          set_req(1'(p), 1'b0);
        end
      end
      model_step();
      tick();
      check_cycle();
    end
    issued0 = issued[0];
    issued1 = issued[1];
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  vec_t vt [12];
  int   i0, i1, mism;
  int   gseq[$];

  initial begin
    vt[0]  = '{1'b0, 1'b0, 9'h010, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
    vt[1]  = '{1'b1, 1'b0, 9'h011, 32'h0,        3'b100, 1'b0, 32'h000000BE};
    vt[2]  = '{1'b0, 1'b0, 9'h011, 32'h0,        3'b000, 1'b0, 32'hFFFFFFBE};
    vt[3]  = '{1'b1, 1'b0, 9'h012, 32'h0,        3'b001, 1'b0, 32'hFFFFDEAD};
    vt[4]  = '{1'b0, 1'b0, 9'h012, 32'h0,        3'b101, 1'b0, 32'h0000DEAD};
    vt[5]  = '{1'b1, 1'b1, 9'h003, 32'h0000BEEF, 3'b001, 1'b1, 32'h00000000};
    vt[6]  = '{1'b0, 1'b0, 9'h002, 32'h0,        3'b010, 1'b1, 32'h00000000};
    vt[7]  = '{1'b1, 1'b1, 9'h030, 32'h00001234, 3'b010, 1'b0, 32'h00000000};
    vt[8]  = '{1'b0, 1'b0, 9'h030, 32'h0,        3'b010, 1'b0, 32'h00001234};
    vt[9]  = '{1'b0, 1'b1, 9'h031, 32'hAAAAAA55, 3'b000, 1'b0, 32'h00000000};
    vt[10] = '{1'b1, 1'b0, 9'h030, 32'h0,        3'b010, 1'b0, 32'h00005534};
    vt[11] = '{1'b0, 1'b0, 9'h011, 32'h0,        3'b001, 1'b1, 32'h00000000};

    for (int i = 0; i < int'(MEM); i++) dmem[i] = 8'(i * 37 + 11);
    dmem[16] = 8'hEF; dmem[17] = 8'hBE; dmem[18] = 8'hAD; dmem[19] = 8'hDE;
    for (int i = 0; i < int'(MEM); i++) ref_mem[i] = dmem[i];

    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("rst_err", 32'({m0_err, m1_err}), 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
    chk("rst_a_wd_f3", 32'(a) | wd | 32'(Funct3), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_single(vt[i]);

    // Simultaneous stores straight after reset: port 0 first, port 1 two cycles later.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 9'h020, 32'h11111111, 3'b010);
    drive(1'b1, 1'b1, 1'b1, 9'h024, 32'h22222222, 3'b010);
    tick();
    chk("sim_gnt0", 32'({m0_gnt, m1_gnt}), 32'b10);
    chk("sim_wr0", 32'({MemWrite, MemRead}), 32'b10);
    chk("sim_a0", 32'(a), 32'h020);
    m0_req = 1'b0;
    tick();
    chk("sim_rv0", 32'({m0_rvalid, m1_gnt, MemWrite}), 32'b100);
    tick();
    chk("sim_gnt1", 32'({m0_gnt, m1_gnt}), 32'b01);
    chk("sim_wr1", 32'({MemWrite, MemRead}), 32'b10);
    chk("sim_a1", 32'(a), 32'h024);
    m1_req = 1'b0;
    tick();
    chk("sim_rv1", 32'(m1_rvalid), 32'd1);
    chk("sim_mem0", env_word(32), 32'h11111111);
    chk("sim_mem1", env_word(36), 32'h22222222);
    begin
      logic [31:0] dr; logic de;
      ref_access(1'b1, 9'h020, 32'h11111111, 3'b010, dr, de);
      ref_access(1'b1, 9'h024, 32'h22222222, 3'b010, dr, de);
    end

    // Reset while a byte store is on the memory bus.
    tick();
    drive(1'b0, 1'b1, 1'b1, 9'h040, 32'h00000077, 3'b000);
    tick();
    chk("rmid_issue", 32'({m0_gnt, MemWrite}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("rmid_async", 32'({m0_gnt, m1_gnt, MemWrite, MemRead, m0_rvalid, m1_rvalid}), 32'd0);
    m0_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rmid_after", 32'({m0_rvalid, m1_rvalid, MemWrite, MemRead}), 32'd0);
    chk("rmid_mem", 32'(dmem[64]), 32'(ref_mem[64]));
    drive(1'b1, 1'b1, 1'b0, 9'h011, 32'h0, 3'b100);
    tick();
    chk("rmid_m1_first", 32'({m0_gnt, m1_gnt}), 32'b01);
    m1_req = 1'b0;
    tick();
    chk("rmid_m1_data", m1_rdata, 32'h000000BE);
    drive(1'b0, 1'b1, 1'b0, 9'h012, 32'h0, 3'b100);
    drive(1'b1, 1'b1, 1'b0, 9'h013, 32'h0, 3'b100);
    tick();
    chk("rmid_tie_m0", 32'({m0_gnt, m1_gnt}), 32'b10);
    m0_req = 1'b0;
    tick();
    chk("rmid_m0_data", m0_rdata, 32'h000000AD);
    tick();
    chk("rmid_m1_next", 32'(m1_gnt), 32'd1);
    m1_req = 1'b0;
    tick();
    chk("rmid_m1_data2", m1_rdata, 32'h000000DE);

    // Port 1 pulses req only during port 0's issue cycle and must never be served.
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    tick();
    chk("wd_m0_gnt", 32'(m0_gnt), 32'd1);
    m0_req = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 9'h014, 32'h0, 3'b010);
    tick();
    chk("wd_m0_rv", 32'({m0_rvalid, m1_gnt}), 32'b10);
    m1_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("wd_quiet", 32'({m1_gnt, m0_gnt, MemRead, MemWrite, m1_rvalid}), 32'd0);
    end

    // Continuous contention with byte loads, then random mixed traffic.
    do_reset();
    gseq.delete();
    run_traffic(40, 1'b1, i0, i1, gseq);
    chk("cont_count0", 32'(i0), 32'd8);
    chk("cont_count1", 32'(i1), 32'd8);
    chk("cont_len", 32'(gseq.size()), 32'd16);
    if (gseq.size() > 0) chk("cont_first", 32'(gseq[0]), 32'd0);
    for (int i = 1; i < gseq.size(); i++) chk("cont_alt", 32'(gseq[i] != gseq[i-1]), 32'd1);

    tick(); tick();
    do_reset();
    run_traffic(3000, 1'b0, i0, i1, gseq);
    tick(); tick();

    mism = 0;
    for (int i = 0; i < int'(MEM); i++) if (dmem[i] !== ref_mem[i]) mism++;
    chk("mem_final", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
